// File: rtl/uc_pkg.sv
// Shared constants for the multicycle control unit: opcode values, prefix masks,
// FSM state encoding and the EXEC control word.
package uc_pkg;

  localparam logic [5:0] OP_J    = 6'b110000;
  localparam logic [5:0] OP_JZ   = 6'b110001;
  localparam logic [5:0] OP_JNZ  = 6'b110010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // Instruction classes selected by leading opcode bits
  localparam logic [5:0] MASK_ALU = 6'b100000;
  localparam logic [5:0] PFX_ALU  = 6'b000000;
  localparam logic [5:0] MASK_LI  = 6'b110000;
  localparam logic [5:0] PFX_LI   = 6'b100000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic       pc_we;
    logic [2:0] op;
    logic       halt;
    logic       illegal;
  } ctrl_t;

  // Quiescent word driven in FETCH and HALT: no writes, PC mux parked on PC+1
  localparam ctrl_t CTRL_IDLE = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0,
                                  pc_we: 1'b0, op: 3'b000, halt: 1'b0, illegal: 1'b0};

  localparam ctrl_t CTRL_NOP  = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0,
                                  pc_we: 1'b1, op: 3'b000, halt: 1'b0, illegal: 1'b0};

  function automatic logic prefix_match(input logic [5:0] opc, input logic [5:0] mask,
                                        input logic [5:0] pfx);
    return (opc & mask) == pfx;
  endfunction

endpackage

// File: rtl/uc_dec.sv
// Combinational instruction decoder: maps opcode and zero flag to the EXEC-cycle control word.
// Reserved opcodes decode as a NOP with the illegal marker raised.
module uc_dec
  import uc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic       z_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_NOP;
    if (prefix_match(opcode_i, MASK_ALU, PFX_ALU)) begin
      ctrl_o.op  = opcode_i[4:2];
      ctrl_o.we3 = 1'b1;
      ctrl_o.wez = 1'b1;
    end else if (prefix_match(opcode_i, MASK_LI, PFX_LI)) begin
      ctrl_o.s_inm = 1'b1;
      ctrl_o.we3   = 1'b1;
    end else begin
      case (opcode_i)
        OP_J:    ctrl_o.s_inc = 1'b0;
        OP_JZ:   ctrl_o.s_inc = ~z_i;
        OP_JNZ:  ctrl_o.s_inc = z_i;
        OP_HALT: begin
          ctrl_o.pc_we = 1'b0;
          ctrl_o.halt  = 1'b1;
        end
        default: ctrl_o.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uc_multicycle.sv
// Multicycle control unit: FETCH/EXEC/HALT sequencer, retired-instruction counter, sticky illegal flag.
// Optional single-step handshake (step_req/step_ack) when UC_STEP_EN is defined.
module uc_multicycle
  import uc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
`ifdef UC_STEP_EN
  input  logic             step_req,
  output logic             step_ack,
`endif
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_we,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] retired_d;
  logic             illegal_q;
  logic             step_go;
  ctrl_t            dec_ctrl;
  ctrl_t            ctl;

  uc_dec u_dec (
    .opcode_i (Opcode),
    .z_i      (z),
    .ctrl_o   (dec_ctrl)
  );

`ifdef UC_STEP_EN
  assign step_go  = step_req;
  assign step_ack = (state_q == S_EXEC);
`else
  assign step_go  = 1'b1;
`endif

  assign retired_d = retired_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: if (step_go) state_q <= S_EXEC;
        S_EXEC: begin
          retired_q <= retired_d;
          if (dec_ctrl.illegal) illegal_q <= 1'b1;
          state_q <= dec_ctrl.halt ? S_HALT : S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Enables are masked while reset is high so an interrupted EXEC commits nothing
  always_comb begin
    ctl = CTRL_IDLE;
    if (state_q == S_EXEC) ctl = dec_ctrl;
    if (reset) begin
      ctl.we3   = 1'b0;
      ctl.wez   = 1'b0;
      ctl.pc_we = 1'b0;
    end
  end

  assign s_inc   = ctl.s_inc;
  assign s_inm   = ctl.s_inm;
  assign we3     = ctl.we3;
  assign wez     = ctl.wez;
  assign Op      = ctl.op;
  assign pc_we   = ctl.pc_we;
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_uc_multicycle.sv
// Self-checking bench for uc_multicycle against a cycle-level reference model.
module tb_uc_multicycle;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    Opcode = 6'd0;
  logic          z = 1'b0;
  logic          s_inc, s_inm, we3, wez, pc_we, halted, illegal;
  logic [2:0]    Op;
  logic [CW-1:0] retired;
`ifdef UC_STEP_EN
  logic          step_req = 1'b1;
  logic          step_ack;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: phase 0 = fetch, 1 = execute, 2 = halted
  int            m_ph = 0;
  logic [CW-1:0] m_ret = '0;
  logic          m_ill = 1'b0;

  uc_multicycle #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z),
`ifdef UC_STEP_EN
    .step_req(step_req), .step_ack(step_ack),
`endif
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
    .pc_we(pc_we), .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  // {s_inc, s_inm, we3, wez, pc_we, Op[2:0]} expected for a phase/opcode/z
  function automatic logic [7:0] exp_ctrl(input int ph, input logic [5:0] opc, input logic zz);
    int v;
    v = int'(opc);
    if (ph != 1) return 8'b1000_0000;
    if (v < 32)  return {5'b10111, opc[4:2]};
    if (v < 48)  return 8'b1110_1000;
    if (v == 48) return 8'b0000_1000;
    if (v == 49) return {~zz, 7'b000_1000};
    if (v == 50) return {zz, 7'b000_1000};
    if (v == 63) return 8'b1000_0000;
    return 8'b1000_1000;
  endfunction

  function automatic logic [7:0] obs_ctrl();
    return {s_inc, s_inm, we3, wez, pc_we, Op};
  endfunction

  task automatic apply(input logic [5:0] opc, input logic zz);
    Opcode = opc;
    z = zz;
    #1;
  endtask

  task automatic tick();
    logic go;
    go = 1'b1;
`ifdef UC_STEP_EN
    go = step_req;
`endif
    @(posedge clk);
    if (reset) begin
      m_ph = 0; m_ret = '0; m_ill = 1'b0;
    end else if (m_ph == 0) begin
      if (go) m_ph = 1;
    end else if (m_ph == 1) begin
      m_ret = m_ret + 1'b1;
      if (Opcode >= 6'd51 && Opcode <= 6'd62) m_ill = 1'b1;
      m_ph = (Opcode == 6'd63) ? 2 : 0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic run_instr(input logic [5:0] opc, input logic zz);
    apply(opc, zz);
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    apply(6'b001100, 1'b0);
    n_chk++; if (obs_ctrl() !== 8'b1000_0000) begin n_fail++; $display("FAIL reset_ctl got %b want %b", obs_ctrl(), 8'b1000_0000); end
    n_chk++; if (retired !== '0) begin n_fail++; $display("FAIL reset_retired got %0d want 0", retired); end
    n_chk++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", illegal); end
    n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
  endtask

  task automatic test_alu();
    do_reset();
    apply(6'b001100, 1'b0);
    n_chk++; if (obs_ctrl() !== 8'b1000_0000) begin n_fail++; $display("FAIL alu_fetch got %b want %b", obs_ctrl(), 8'b1000_0000); end
    tick();
    n_chk++; if (obs_ctrl() !== 8'b1011_1011) begin n_fail++; $display("FAIL alu_exec got %b want %b", obs_ctrl(), 8'b1011_1011); end
    tick();
    n_chk++; if (retired !== 4'd1) begin n_fail++; $display("FAIL alu_retired got %0d want 1", retired); end
  endtask

  task automatic test_load_imm();
    apply(6'b100000, 1'b1);
    tick();
    n_chk++; if (obs_ctrl() !== 8'b1110_1000) begin n_fail++; $display("FAIL li_exec got %b want %b", obs_ctrl(), 8'b1110_1000); end
    tick();
  endtask

  task automatic test_jumps();
    logic [5:0] opcs [4];
    logic       zs   [4];
    logic       want [4];
    opcs = '{6'b110001, 6'b110001, 6'b110010, 6'b110000};
    zs   = '{1'b1, 1'b0, 1'b1, 1'b1};
    want = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      apply(opcs[i], zs[i]);
      tick();
      n_chk++; if (s_inc !== want[i] || pc_we !== 1'b1) begin
        n_fail++; $display("FAIL jump%0d s_inc/pc_we got %b%b want %b1", i, s_inc, pc_we, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_reserved_halt();
    logic [CW-1:0] frozen;
    run_instr(6'b110100, 1'b0);
    n_chk++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_set got %b want 1", illegal); end
    for (int i = 0; i < 5; i++) run_instr(6'b000100, 1'b0);
    n_chk++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky got %b want 1", illegal); end
    apply(6'b111111, 1'b0);
    tick();
    n_chk++; if (obs_ctrl() !== 8'b1000_0000) begin n_fail++; $display("FAIL halt_exec got %b want %b", obs_ctrl(), 8'b1000_0000); end
    tick();
    frozen = m_ret;
    for (int i = 0; i < 20; i++) begin
      apply(6'($urandom_range(0, 63)), 1'($urandom));
      n_chk++; if (halted !== 1'b1 || pc_we !== 1'b0 || retired !== frozen) begin
        n_fail++; $display("FAIL halt_hold cyc%0d halted=%b pc_we=%b retired=%0d want 1 0 %0d", i, halted, pc_we, retired, frozen);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_instr(6'b111000, 1'b0);
    for (int i = 0; i < 4; i++) run_instr(6'b010000, 1'b1);
    apply(6'b000000, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    n_chk++; if (we3 !== 1'b0 || pc_we !== 1'b0) begin n_fail++; $display("FAIL mid_reset_gate we3=%b pc_we=%b want 0 0", we3, pc_we); end
    tick();
    reset = 1'b0;
    #1;
    n_chk++; if (retired !== '0 || illegal !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_state retired=%0d illegal=%b halted=%b want 0 0 0", retired, illegal, halted);
    end
    n_chk++; if (obs_ctrl() !== 8'b1000_0000) begin n_fail++; $display("FAIL mid_reset_fetch got %b want %b", obs_ctrl(), 8'b1000_0000); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_instr(6'b000000, 1'b0);
      if (i == 14) begin
        n_chk++; if (retired !== 4'hF) begin n_fail++; $display("FAIL wrap_max got %0d want 15", retired); end
      end
    end
    n_chk++; if (retired !== 4'h0) begin n_fail++; $display("FAIL wrap_zero got %0d want 0", retired); end
  endtask

  task automatic test_random();
    logic [5:0] opc;
    int         r, halt_cnt;
    do_reset();
    halt_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 15);
      if (r < 6)        opc = {1'b0, 5'($urandom)};
      else if (r < 8)   opc = {2'b10, 4'($urandom)};
      else if (r == 8)  opc = 6'b110000;
      else if (r < 11)  opc = 6'b110001;
      else if (r < 13)  opc = 6'b110010;
      else if (r == 13) opc = 6'($urandom_range(51, 62));
      else if (r == 14) opc = 6'b111111;
      else              opc = 6'($urandom);
      apply(opc, 1'($urandom));
      n_chk++; if (obs_ctrl() !== exp_ctrl(m_ph, Opcode, z)) begin
        n_fail++; $display("FAIL rnd_ctl cyc%0d op=%b got %b want %b", i, Opcode, obs_ctrl(), exp_ctrl(m_ph, Opcode, z));
      end
      n_chk++; if (retired !== m_ret || illegal !== m_ill || halted !== (m_ph == 2)) begin
        n_fail++; $display("FAIL rnd_state cyc%0d got ret=%0d ill=%b hlt=%b want %0d %b %b", i, retired, illegal, halted, m_ret, m_ill, m_ph == 2);
      end
      tick();
      if (m_ph == 2) halt_cnt++;
      if (halt_cnt > 3) begin
        do_reset();
        halt_cnt = 0;
      end
    end
  endtask

`ifdef UC_STEP_EN
  task automatic test_step();
    int acks;
    do_reset();
    step_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apply(6'b000100, 1'b0);
      n_chk++; if (pc_we !== 1'b0 || step_ack !== 1'b0) begin n_fail++; $display("FAIL step_wait cyc%0d pc_we=%b ack=%b want 0 0", i, pc_we, step_ack); end
      tick();
    end
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (step_ack === 1'b1) acks++;
      tick();
    end
    n_chk++; if (acks != 1) begin n_fail++; $display("FAIL step_once acks=%0d want 1", acks); end
    n_chk++; if (retired !== 4'd1) begin n_fail++; $display("FAIL step_retired got %0d want 1", retired); end
    step_req = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load_imm();
    test_jumps();
    test_reserved_halt();
    test_reset_mid();
    test_wrap();
    test_random();
`ifdef UC_STEP_EN
    test_step();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uc_multicycle.md
UC_MULTICYCLE -- requirements
Module: uc_multicycle

Interface
REQ-001 Parameter: CNT_W, default 16, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Opcode  input  6  instr[15:10] from the datapath.
REQ-005 z  input  1  registered zero flag from the datapath.
REQ-006 s_inc  output  1  PC mux select: 1 = PC+1, 0 = instr[9:0] jump target.
REQ-007 s_inm  output  1  immediate select for the ALU A operand and register-file RA2.
REQ-008 we3  output  1  register-file write enable.
REQ-009 wez  output  1  zero-flag load enable.
REQ-010 Op  output  3  ALU operation.
REQ-011 pc_we  output  1  PC load enable; the datapath gates its PC register with it.
REQ-012 halted  output  1  high while in HALT.
REQ-013 illegal  output  1  sticky flag set by a reserved opcode.
REQ-014 retired  output  CNT_W  count of executed instructions.

Function
REQ-015 The FSM SHALL have states FETCH, EXEC and HALT, because program memory reads are synchronous.
REQ-016 In FETCH: pc_we=0, we3=0, wez=0, s_inc=1, s_inm=0, Op=000; FETCH -> EXEC next cycle.
REQ-017 In EXEC, outputs are decoded from Opcode, and the FSM moves EXEC -> FETCH, or EXEC -> HALT on HALT.
REQ-018 Opcode 0ooo_xx is an ALU reg-reg operation: Op=Opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=1, pc_we=1.
REQ-019 Opcode 10xx_xx is a load immediate: s_inm=1, Op=000 (pass A), we3=1, wez=0, s_inc=1, pc_we=1.
REQ-020 Opcode 110000 is J: s_inc=0, pc_we=1, we3=0, wez=0.
REQ-021 Opcode 110001 is JZ: s_inc = ~z, pc_we=1.
REQ-022 Opcode 110010 is JNZ: s_inc = z, pc_we=1.
REQ-023 Opcode 111111 is HALT: all enables 0; the next state is HALT.
REQ-024 Opcodes 110011..111110 are reserved: they execute as NOP (s_inc=1, pc_we=1, no writes) and set illegal=1 until reset.
REQ-025 HALT SHALL hold all enables at 0 with halted=1, and exit only through reset.
REQ-026 retired SHALL increment by 1 on every EXEC cycle, including NOP, jump and HALT; it wraps from all-ones to 0.
REQ-027 Jump conditions SHALL sample z during the EXEC cycle; a wez write in that same cycle affects only the next instruction.

Reset
REQ-028 On reset: state=FETCH, retired=0, illegal=0, halted=0, and all enables 0.
REQ-029 Reset asserted in any state, including mid-EXEC or HALT, SHALL take effect at the next edge; the outputs of that cycle are not committed.

Configuration
REQ-030 Macro UC_STEP_EN SHALL add ports step_req (input, 1) and step_ack (output, 1).
REQ-031 With UC_STEP_EN defined, FETCH waits until step_req=1 before entering EXEC, and step_ack pulses 1 during each EXEC cycle.
REQ-032 Without UC_STEP_EN, these ports are absent and FETCH always advances.

Structure
REQ-033 Package uc_pkg SHALL hold the opcode constants (OP_J, OP_JZ, OP_JNZ, OP_HALT), the prefix masks and the state encoding.
REQ-034 A combinational sub-module uc_dec SHALL map Opcode and z to the EXEC control word; uc_multicycle holds the FSM, counter and flags.

Verification
REQ-035 ALU op: Opcode=0_011_00 after reset -> FETCH all-zero, then EXEC Op=011, we3=1, wez=1, pc_we=1, s_inc=1; retired=1.
REQ-036 Load immediate: Opcode=100000 -> EXEC s_inm=1, Op=000, we3=1, wez=0.
REQ-037 Conditional jump: JZ with z=1 -> s_inc=0; JZ with z=0 -> s_inc=1; JNZ with z=1 -> s_inc=1.
REQ-038 Reserved and HALT: Opcode=110100 -> illegal=1, still set 10 cycles later; then HALT -> halted=1 and pc_we=0 for 20 cycles, retired frozen.
REQ-039 Reset mid-run: reset asserted during EXEC after 5 instructions -> next cycle state=FETCH, retired=0, illegal=0, halted=0.
REQ-040 Step mode (UC_STEP_EN): step_req=0 for 8 cycles -> pc_we=0 throughout; a single step_req pulse -> exactly one EXEC and one step_ack.
